// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle: imem req/ack, branch redirect, decode queue head, rf pc
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        br_valid;
   logic [31:0] br_target;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] rf_pc_out;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc, rf_pc_out,
      input  imem_ack, imem_rdata, br_valid, br_target, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc, rf_pc_out,
      output imem_ack, imem_rdata, br_valid, br_target, id_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: pc, imem req/ack, 2-entry decode queue, branch redirect
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk_i,
   input logic          reset_i,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_pc_q;
   logic [31:0] rf_pc_q;
   logic [31:0] q_pc_q    [2];
   logic [31:0] q_instr_q [2];
   logic        head_q;
   logic [1:0]  count_q;

   logic [31:0] tgt;
   logic        br;
   logic        pop;
   logic        push;
   logic        wr_ptr;
   logic [1:0]  count_d;

   always_comb begin
      tgt     = {bus.br_target[31:2], 2'b00};
      br      = bus.br_valid;
      pop     = (count_q != 2'd0) && bus.id_ready && !br;
      push    = (state_q == S_REQ) && bus.imem_ack && !br;
      wr_ptr  = head_q ^ count_q[0];
      count_d = br ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         pend_pc_q <= RESET_PC;
         rf_pc_q   <= RESET_PC;
         head_q    <= 1'b0;
         count_q   <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            q_pc_q[i]    <= 32'h0;
            q_instr_q[i] <= 32'h0;
         end
      end else begin
         rf_pc_q <= pc_q;
         count_q <= count_d;
         if (push) begin
            q_pc_q[wr_ptr]    <= pc_q;
            q_instr_q[wr_ptr] <= bus.imem_rdata;
         end
         if (pop) head_q <= ~head_q;

         case (state_q)
            S_IDLE: begin
               if (br) begin
                  pc_q    <= tgt;
                  state_q <= S_REQ;
               end else if (count_d < 2'd2) begin
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (br) begin
                  // A redirect without ack leaves a stale request in flight that must be drained.
                  if (bus.imem_ack) begin
                     pc_q <= tgt;
                  end else begin
                     pend_pc_q <= tgt;
                     state_q   <= S_DROP;
                  end
               end else if (bus.imem_ack) begin
                  pc_q    <= pc_q + 32'd4;
                  state_q <= (count_d < 2'd2) ? S_REQ : S_IDLE;
               end
            end
            S_DROP: begin
               if (bus.imem_ack) begin
                  pc_q    <= br ? tgt : pend_pc_q;
                  state_q <= S_REQ;
               end else if (br) begin
                  pend_pc_q <= tgt;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.imem_req  = (state_q != S_IDLE);
   assign bus.imem_addr = pc_q;
   assign bus.id_valid  = (count_q != 2'd0) && !br;
   assign bus.id_instr  = q_instr_q[head_q];
   assign bus.id_pc     = q_pc_q[head_q];
   assign bus.rf_pc_out = rf_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a zero-wait gated memory responder
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ack_en;
   logic        id_ready;
   logic        br_valid;
   logic [31:0] br_target;
   int          tests_run = 0;
   int          fails = 0;

   localparam logic [31:0] XORV = 32'hA5A5_A5A5;

   fetch_unit_if u_if1 ();
   fetch_unit_if u_if2 ();

   assign u_if1.imem_ack   = u_if1.imem_req && ack_en;
   assign u_if1.imem_rdata = u_if1.imem_addr ^ XORV;
   assign u_if1.br_valid   = br_valid;
   assign u_if1.br_target  = br_target;
   assign u_if1.id_ready   = id_ready;

   assign u_if2.imem_ack   = u_if2.imem_req && ack_en;
   assign u_if2.imem_rdata = u_if2.imem_addr ^ XORV;
   assign u_if2.br_valid   = 1'b0;
   assign u_if2.br_target  = 32'h0;
   assign u_if2.id_ready   = id_ready;

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut1 (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (u_if1.master)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (u_if2.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; ack_en = 1'b0; id_ready = 1'b0; br_valid = 1'b0; br_target = 32'h0;

      // reset held two cycles
      tick;
      chk("rst_req",    {31'b0, u_if1.imem_req}, 32'd0);
      chk("rst_valid",  {31'b0, u_if1.id_valid}, 32'd0);
      chk("rst_rfpc",   u_if1.rf_pc_out, 32'h0);
      chk("rst_addr",   u_if1.imem_addr, 32'h0);
      chk("rst_instr",  u_if1.id_instr,  32'h0);
      chk("rst_idpc",   u_if1.id_pc,     32'h0);
      chk("rst2_rfpc",  u_if2.rf_pc_out, 32'hFFFF_FFF8);
      tick;
      chk("rst_req_2",  {31'b0, u_if1.imem_req}, 32'd0);
      chk("rst_valid_2",{31'b0, u_if1.id_valid}, 32'd0);
      reset = 1'b0;
      tick;
      chk("first_req",  {31'b0, u_if1.imem_req}, 32'd1);
      chk("first_addr", u_if1.imem_addr, 32'h0);
      chk("first_addr2",u_if2.imem_addr, 32'hFFFF_FFF8);

      // sustained zero-wait stream
      ack_en = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("stream_valid", {31'b0, u_if1.id_valid}, 32'd1);
         chk("stream_pc",    u_if1.id_pc, 32'(4 * i));
         chk("stream_instr", u_if1.id_instr, 32'(4 * i) ^ XORV);
         if (i == 0) begin
            chk("wrap_addr_fffc", u_if2.imem_addr, 32'hFFFF_FFFC);
            chk("wrap_idpc_fff8", u_if2.id_pc, 32'hFFFF_FFF8);
         end
         if (i == 1) chk("wrap_addr_0", u_if2.imem_addr, 32'h0);
      end

      // decode stalled from the start: queue fills, then drains in order
      reset = 1'b1; ack_en = 1'b0; id_ready = 1'b0;
      tick;
      reset = 1'b0;
      tick;
      ack_en = 1'b1;
      tick;
      chk("stall_addr4", u_if1.imem_addr, 32'h4);
      chk("stall_head0", u_if1.id_pc, 32'h0);
      tick;
      chk("stall_req_off",  {31'b0, u_if1.imem_req}, 32'd0);
      tick;
      chk("stall_req_off2", {31'b0, u_if1.imem_req}, 32'd0);
      chk("stall_full_valid", {31'b0, u_if1.id_valid}, 32'd1);
      chk("stall_full_head", u_if1.id_pc, 32'h0);
      id_ready = 1'b1;
      tick;
      chk("drain_head4", u_if1.id_pc, 32'h4);
      chk("drain_instr4", u_if1.id_instr, 32'h4 ^ XORV);
      chk("drain_addr8", u_if1.imem_addr, 32'h8);
      tick;
      chk("drain_head8", u_if1.id_pc, 32'h8);
      chk("drain_valid8", {31'b0, u_if1.id_valid}, 32'd1);
      tick;
      chk("drain_head12", u_if1.id_pc, 32'hC);

      // redirect coincident with ack of 0x8
      reset = 1'b1; ack_en = 1'b0; id_ready = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      ack_en = 1'b1;
      tick;
      tick;
      chk("br1_addr8", u_if1.imem_addr, 32'h8);
      br_valid = 1'b1; br_target = 32'h103;
      #1;
      chk("br1_valid_override", {31'b0, u_if1.id_valid}, 32'd0);
      tick;
      br_valid = 1'b0; ack_en = 1'b0;
      chk("br1_flushed", {31'b0, u_if1.id_valid}, 32'd0);
      chk("br1_addr_tgt", u_if1.imem_addr, 32'h100);
      chk("br1_req", {31'b0, u_if1.imem_req}, 32'd1);
      chk("br1_rfpc_old", u_if1.rf_pc_out, 32'h8);
      tick;
      chk("br1_rfpc_new", u_if1.rf_pc_out, 32'h100);
      chk("br1_empty", {31'b0, u_if1.id_valid}, 32'd0);

      // redirect while 0x8 is pending, second redirect while draining the stale request
      reset = 1'b1; ack_en = 1'b0; id_ready = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      ack_en = 1'b1;
      tick;
      tick;
      ack_en = 1'b0; br_valid = 1'b1; br_target = 32'h200;
      tick;
      chk("drop_addr_c4", u_if1.imem_addr, 32'h8);
      chk("drop_req_c4",  {31'b0, u_if1.imem_req}, 32'd1);
      br_target = 32'h300;
      #1;
      chk("drop_valid_c4", {31'b0, u_if1.id_valid}, 32'd0);
      tick;
      br_valid = 1'b0;
      chk("drop_addr_c5", u_if1.imem_addr, 32'h8);
      tick;
      chk("drop_addr_c6", u_if1.imem_addr, 32'h8);
      tick;
      chk("drop_addr_c7", u_if1.imem_addr, 32'h8);
      chk("drop_valid_c7", {31'b0, u_if1.id_valid}, 32'd0);
      ack_en = 1'b1;
      tick;
      chk("drop_new_addr", u_if1.imem_addr, 32'h300);
      chk("drop_discard", {31'b0, u_if1.id_valid}, 32'd0);
      tick;
      chk("drop_first_valid", {31'b0, u_if1.id_valid}, 32'd1);
      chk("drop_first_pc", u_if1.id_pc, 32'h300);
      chk("drop_first_instr", u_if1.id_instr, 32'h300 ^ XORV);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the register file and decode. Owns the architectural fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue toward decode with valid/ready flow control. Accepts branch redirects from execute, flushing queued and in-flight instructions. Drives the next-fetch PC to the register file's PC input.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  request valid; held until imem_ack
- imem_addr  out  32  word-aligned request address; stable while imem_req=1
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- br_valid  in  1  redirect from execute, single-cycle pulse
- br_target  in  32  redirect address; bits [1:0] ignored, treated as 0
- id_valid  out  1  queue head valid toward decode
- id_ready  in  1  decode accepts head this cycle
- id_instr  out  32  queue head instruction
- id_pc  out  32  address of queue head instruction
- rf_pc_out  out  32  next fetch address (pc register); to register file PC input

## Operation
- Registers: pc (next/current request address), pend_pc (redirect target held during DROP), 2-entry queue of {pc, instr}, count (0..2), state.
- States: IDLE (imem_req=0), REQ (imem_req=1, imem_addr=pc), DROP (imem_req=1, imem_addr=pc, response discarded).
- Pop: id_valid && id_ready && !br_valid. id_valid = (count != 0) && !br_valid.
- IDLE: br_valid -> flush queue, pc <= {br_target[31:2],2'b00}, go REQ. Else go REQ if count after this cycle's pop < 2, else stay.
- REQ, no br_valid: on imem_ack push {pc, imem_rdata}, pc <= pc + 4; next REQ if count_next < 2, else IDLE. No ack: stay.
- REQ, br_valid with imem_ack: flush, discard rdata, pc <= target, stay REQ (new address next cycle).
- REQ, br_valid without imem_ack: flush, pend_pc <= target, go DROP.
- DROP: br_valid -> pend_pc <= new target (latest wins); queue stays empty. On imem_ack: discard rdata, pc <= pend_pc (or same-cycle br_target if br_valid), go REQ.
- Push and pop same cycle: count unchanged, FIFO order preserved.
- Queue cannot overflow: request issued only with count <= 1; count rises only via the ack of that request.
- pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- br_valid always overrides pop and push in the same cycle.

## Timing
- Reset (sampled high at edge): state IDLE, count 0, pc = pend_pc = RESET_PC. Outputs: imem_req 0, imem_addr RESET_PC, id_valid 0, id_instr 0, id_pc 0, rf_pc_out RESET_PC.
- Reset mid-REQ/DROP abandons the outstanding request; instruction memory is reset on the same clock.
- First imem_req=1 in cycle after reset deasserts (IDLE -> REQ at first non-reset edge).
- imem_ack sampled at edge; pushed instruction visible on id_valid the next cycle (1-cycle ack-to-decode latency).
- Zero-wait memory plus id_ready=1: one instruction per cycle sustained, count steady at 1.
- Redirect: first request to target in cycle after br_valid (REQ/IDLE) or cycle after stale ack (DROP).
- rf_pc_out updates the cycle after pc changes.

## Test plan
- Reset held 2 cycles, RESET_PC=0 -> imem_req=0, id_valid=0, rf_pc_out=0 during reset; imem_req=1, imem_addr=0 first cycle after release.
- Ack every cycle, rdata=addr^32'hA5A5A5A5, id_ready=1 -> id_pc 0,4,8,12 on consecutive cycles, id_instr matching, no bubbles.
- id_ready=0 from start -> two acks accepted (0,4), imem_req drops; id_ready=1 -> heads 0,4,8 delivered in order, none lost or duplicated.
- br_valid, target 0x103, coincident with ack of 0x8 -> 0x8 not delivered, queue empty, next imem_addr 0x100.
- Request 0x8 pending, br_valid target 0x200, second br_valid 0x300 next cycle, ack 3 cycles later -> imem_addr held 0x8 until ack, data dropped, next request 0x300, first id_pc 0x300.
- RESET_PC=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
